// File: rtl/big_fv_pingpong_array.sv
// Banked ping-pong big-FV memory: edge-PE read/write streams per bank plus all-bank broadcast streams.
// Optional protocol checker enabled by defining BIG_FV_PROTOCOL_CHK_EN (proto_err tied low otherwise).
module big_fv_pingpong_array #(
  parameter  int NUM_BANKS      = 4,
  parameter  int FV_W           = 16,
  parameter  int NODES_PER_BANK = 16,
  parameter  int MAX_BEATS      = 4,
  parameter  int PE_TAG_W       = 2,
  localparam int NODE_W         = $clog2(NODES_PER_BANK),
  localparam int BEAT_W         = $clog2(MAX_BEATS) + 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [BEAT_W-1:0]             fv_num,
  input  logic [NODE_W:0]               stream_nodes,
  input  logic                          stream_begin,
  input  logic                          swap,
  input  logic [NUM_BANKS-1:0]          req_valid,
  output logic [NUM_BANKS-1:0]          req_ready,
  input  logic [NUM_BANKS-1:0]          req_rd_wr,
  input  logic [NUM_BANKS*PE_TAG_W-1:0] req_pe_tag,
  input  logic [NUM_BANKS*NODE_W-1:0]   req_node_id,
  input  logic [NUM_BANKS*FV_W-1:0]     req_data,
  input  logic [NUM_BANKS-1:0]          req_sos,
  input  logic [NUM_BANKS-1:0]          req_eos,
  output logic [NUM_BANKS-1:0]          rd_valid,
  output logic [NUM_BANKS-1:0]          rd_sos,
  output logic [NUM_BANKS-1:0]          rd_eos,
  output logic [NUM_BANKS*PE_TAG_W-1:0] rd_pe_tag,
  output logic [NUM_BANKS*FV_W-1:0]     rd_data,
  output logic [NUM_BANKS-1:0]          sm_valid,
  output logic [NUM_BANKS-1:0]          sm_sos,
  output logic [NUM_BANKS-1:0]          sm_eos,
  output logic [NUM_BANKS*NODE_W-1:0]   sm_addr,
  output logic [NUM_BANKS*FV_W-1:0]     sm_data,
  output logic                          half_sel,
  output logic                          available,
  output logic [NUM_BANKS-1:0]          proto_err
);

  localparam int BIDX_W = $clog2(MAX_BEATS);
  localparam int ADDR_W = NODE_W + BIDX_W;
  localparam int DEPTH  = NODES_PER_BANK * MAX_BEATS;

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_STREAM} state_t;

  logic                 half_sel_q;
  logic [NUM_BANKS-1:0] idle;
  logic                 stream_go;
  logic [BEAT_W-1:0]    fv_eff;

  assign available = &idle;
  assign half_sel  = half_sel_q;
  assign stream_go = stream_begin && available;

  // Zero beats behaves as one; oversize counts are clamped to the slot size.
  always_comb begin
    fv_eff = fv_num;
    if (fv_num == '0) fv_eff = BEAT_W'(1);
    else if (fv_num > BEAT_W'(MAX_BEATS)) fv_eff = BEAT_W'(MAX_BEATS);
  end

  always_ff @(posedge clk) begin
    if (reset) half_sel_q <= 1'b0;
    else if (swap && available && !stream_begin) half_sel_q <= ~half_sel_q;
  end

  genvar b;
  for (b = 0; b < NUM_BANKS; b++) begin : g_bank
    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   cnt_q, cnt_d;
    logic [NODE_W:0]     node_q, node_d;
    logic [PE_TAG_W-1:0] tag_q, tag_d;
    logic                acc, we, rd_fire, sm_fire, first, last;
    logic [ADDR_W-1:0]   waddr, raddr;
    logic [NODE_W-1:0]   id_in;
    logic [FV_W-1:0]     wdat, rdat;
    logic [FV_W-1:0]     mem_q [2][DEPTH];
    logic                rd_valid_q, rd_sos_q, rd_eos_q, sm_valid_q, sm_sos_q, sm_eos_q;
    logic [PE_TAG_W-1:0] rd_tag_q;
    logic [FV_W-1:0]     rd_data_q, sm_data_q;
    logic [NODE_W-1:0]   sm_addr_q;

    assign id_in        = req_node_id[b*NODE_W +: NODE_W];
    assign wdat         = req_data[b*FV_W +: FV_W];
    assign req_ready[b] = (state_q == S_IDLE && !stream_begin) || state_q == S_WR;
    assign acc          = req_valid[b] && req_ready[b];
    assign idle[b]      = (state_q == S_IDLE);
    assign first        = (cnt_q == '0);
    assign last         = ((cnt_q + BEAT_W'(1)) == fv_eff);
    assign raddr        = {node_q[NODE_W-1:0], cnt_q[BIDX_W-1:0]};
    assign rdat         = mem_q[half_sel_q][raddr];

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      node_d  = node_q;
      tag_d   = tag_q;
      we      = 1'b0;
      waddr   = {node_q[NODE_W-1:0], cnt_q[BIDX_W-1:0]};
      rd_fire = 1'b0;
      sm_fire = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (stream_go) begin
            state_d = S_STREAM;
            node_d  = '0;
            cnt_d   = '0;
          end else if (acc && req_rd_wr[b]) begin
            state_d = S_RD;
            node_d  = {1'b0, id_in};
            tag_d   = req_pe_tag[b*PE_TAG_W +: PE_TAG_W];
            cnt_d   = '0;
          end else if (acc && req_sos[b]) begin
            we     = 1'b1;
            waddr  = {id_in, BIDX_W'(0)};
            node_d = {1'b0, id_in};
            cnt_d  = BEAT_W'(1);
            if (!req_eos[b]) state_d = S_WR;
          end
        end
        S_WR: begin
          // Any beat here is a write beat; sos restarts the vector at beat 0.
          if (acc) begin
            if (req_sos[b]) begin
              we     = 1'b1;
              waddr  = {id_in, BIDX_W'(0)};
              node_d = {1'b0, id_in};
              cnt_d  = BEAT_W'(1);
            end else if (cnt_q < fv_eff) begin
              we    = 1'b1;
              cnt_d = cnt_q + BEAT_W'(1);
            end
            if (req_eos[b]) state_d = S_IDLE;
          end
        end
        S_RD: begin
          rd_fire = 1'b1;
          cnt_d   = cnt_q + BEAT_W'(1);
          if (last) state_d = S_IDLE;
        end
        S_STREAM: begin
          if (node_q >= stream_nodes) begin
            state_d = S_IDLE;
          end else begin
            sm_fire = 1'b1;
            if (last) begin
              cnt_d  = '0;
              node_d = node_q + (NODE_W+1)'(1);
              if ((node_q + (NODE_W+1)'(1)) == stream_nodes) state_d = S_IDLE;
            end else begin
              cnt_d = cnt_q + BEAT_W'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (we) mem_q[~half_sel_q][waddr] <= wdat;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q    <= S_IDLE;
        cnt_q      <= '0;
        node_q     <= '0;
        tag_q      <= '0;
        rd_valid_q <= 1'b0;
        rd_sos_q   <= 1'b0;
        rd_eos_q   <= 1'b0;
        rd_tag_q   <= '0;
        rd_data_q  <= '0;
        sm_valid_q <= 1'b0;
        sm_sos_q   <= 1'b0;
        sm_eos_q   <= 1'b0;
        sm_addr_q  <= '0;
        sm_data_q  <= '0;
      end else begin
        state_q    <= state_d;
        cnt_q      <= cnt_d;
        node_q     <= node_d;
        tag_q      <= tag_d;
        rd_valid_q <= rd_fire;
        rd_sos_q   <= rd_fire && first;
        rd_eos_q   <= rd_fire && last;
        rd_tag_q   <= rd_fire ? tag_q : '0;
        rd_data_q  <= rd_fire ? rdat : '0;
        sm_valid_q <= sm_fire;
        sm_sos_q   <= sm_fire && first;
        sm_eos_q   <= sm_fire && last;
        sm_addr_q  <= sm_fire ? node_q[NODE_W-1:0] : '0;
        sm_data_q  <= sm_fire ? rdat : '0;
      end
    end

    assign rd_valid[b]                      = rd_valid_q;
    assign rd_sos[b]                        = rd_sos_q;
    assign rd_eos[b]                        = rd_eos_q;
    assign rd_pe_tag[b*PE_TAG_W +: PE_TAG_W] = rd_tag_q;
    assign rd_data[b*FV_W +: FV_W]          = rd_data_q;
    assign sm_valid[b]                      = sm_valid_q;
    assign sm_sos[b]                        = sm_sos_q;
    assign sm_eos[b]                        = sm_eos_q;
    assign sm_addr[b*NODE_W +: NODE_W]      = sm_addr_q;
    assign sm_data[b*FV_W +: FV_W]          = sm_data_q;

`ifdef BIG_FV_PROTOCOL_CHK_EN
    logic err, perr_q;
    // Headless write, sos mid-vector, overlong vector, or eos before the full count.
    assign err = acc && ((state_q == S_IDLE && !req_rd_wr[b] && !req_sos[b]) ||
                         (state_q == S_WR && req_sos[b]) ||
                         (state_q == S_WR && !req_sos[b] && cnt_q >= fv_eff) ||
                         (we && req_eos[b] && cnt_d < fv_eff));
    always_ff @(posedge clk) begin
      if (reset) perr_q <= 1'b0;
      else if (err) perr_q <= 1'b1;
    end
    assign proto_err[b] = perr_q;
`else
    assign proto_err[b] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_big_fv_pingpong_array.sv
// Directed-sequence bench with random data, checked against a per-bank/per-half array model.
module tb_big_fv_pingpong_array;
  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  fv_num;
  logic [4:0]  stream_nodes;
  logic        stream_begin, swap;
  logic [3:0]  req_valid, req_ready, req_rd_wr, req_sos, req_eos;
  logic [7:0]  req_pe_tag;
  logic [15:0] req_node_id;
  logic [63:0] req_data;
  logic [3:0]  rd_valid, rd_sos, rd_eos, sm_valid, sm_sos, sm_eos, proto_err;
  logic [7:0]  rd_pe_tag;
  logic [63:0] rd_data, sm_data;
  logic [15:0] sm_addr;
  logic        half_sel, available;

  big_fv_pingpong_array dut (
    .clk(clk), .reset(reset), .fv_num(fv_num), .stream_nodes(stream_nodes),
    .stream_begin(stream_begin), .swap(swap),
    .req_valid(req_valid), .req_ready(req_ready), .req_rd_wr(req_rd_wr),
    .req_pe_tag(req_pe_tag), .req_node_id(req_node_id), .req_data(req_data),
    .req_sos(req_sos), .req_eos(req_eos),
    .rd_valid(rd_valid), .rd_sos(rd_sos), .rd_eos(rd_eos), .rd_pe_tag(rd_pe_tag), .rd_data(rd_data),
    .sm_valid(sm_valid), .sm_sos(sm_sos), .sm_eos(sm_eos), .sm_addr(sm_addr), .sm_data(sm_data),
    .half_sel(half_sel), .available(available), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [15:0] mdl [4][2][16][4];
  logic [15:0] wbuf [8];
  int hsel = 0;
  int fv = 4;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // A vector of nb beats; only the first fv beats land in memory (the write half).
  task automatic wr_burst(input int b, input int node, input int nb);
    for (int i = 0; i < nb; i++) begin
      req_valid[b] = 1'b1; req_rd_wr[b] = 1'b0;
      req_sos[b] = (i == 0); req_eos[b] = (i == nb - 1);
      req_node_id[b*4 +: 4] = node[3:0];
      req_data[b*16 +: 16] = wbuf[i];
      #1;
      chk("wr_ready", req_ready[b], 1'b1);
      if (i < fv) mdl[b][1-hsel][node][i] = wbuf[i];
      tick;
    end
    req_valid[b] = 1'b0; req_sos[b] = 1'b0; req_eos[b] = 1'b0;
  endtask

  task automatic do_swap(input bit toggles);
    swap = 1'b1;
    tick;
    swap = 1'b0;
    if (toggles) hsel = 1 - hsel;
    #1;
    chk("half_sel_swap", half_sel, hsel[0]);
  endtask

  task automatic rd_issue(input int b, input int node, input int tag);
    int w = 0;
    req_valid[b] = 1'b1; req_rd_wr[b] = 1'b1; req_sos[b] = 1'b0; req_eos[b] = 1'b0;
    req_node_id[b*4 +: 4] = node[3:0];
    req_pe_tag[b*2 +: 2] = tag[1:0];
    #1;
    while (!req_ready[b] && w < 100) begin
      tick; #1; w++;
    end
    chk("rd_accept", req_ready[b], 1'b1);
    tick;
  endtask

  // Called in the cycle after acceptance; beat k is expected k+1 cycles later.
  task automatic rd_collect(input int b, input int node, input int tag, input int nb, input bit swap_mid);
    req_valid[b] = 1'b0;
    if (swap_mid) swap = 1'b1;
    tick;
    swap = 1'b0;
    for (int k = 0; k < nb; k++) begin
      #1;
      chk("rd_valid", rd_valid[b], 1'b1);
      chk("rd_data", rd_data[b*16 +: 16], mdl[b][hsel][node][k]);
      chk("rd_sos", rd_sos[b], k == 0);
      chk("rd_eos", rd_eos[b], k == nb - 1);
      chk("rd_tag", rd_pe_tag[b*2 +: 2], tag[1:0]);
      tick;
    end
    #1;
    chk("rd_done", rd_valid[b], 1'b0);
    chk("half_sel_hold", half_sel, hsel[0]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int tag;
    logic [3:0] exp_perr;
    reset = 1'b1; fv_num = 3'd4; stream_nodes = '0; stream_begin = 1'b0; swap = 1'b0;
    req_valid = '0; req_rd_wr = '0; req_sos = '0; req_eos = '0;
    req_pe_tag = '0; req_node_id = '0; req_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_available", available, 1'b1);
    chk("rst_half_sel", half_sel, 1'b0);
    chk("rst_rd_valid", rd_valid, 4'h0);
    chk("rst_sm_valid", sm_valid, 4'h0);
    chk("rst_proto_err", proto_err, 4'h0);
    chk("rst_rd_data", rd_data, 64'h0);
    reset = 1'b0;
    tick;

    // Bank1 node3 write, swap, read back with tag 2.
    fv = 4; fv_num = 3'd4;
    for (int i = 0; i < 4; i++) wbuf[i] = 16'hA0 + 16'(i);
    wr_burst(1, 3, 4);
    do_swap(1'b1);
    rd_issue(1, 3, 2);
    chk("t1_avail_busy", available, 1'b0);
    chk("t1_ready_busy", req_ready[1], 1'b0);
    rd_collect(1, 3, 2, 4, 1'b0);

    // All banks nodes 0..1, swap, broadcast stream; bank2 read held across the stream.
    fv = 2; fv_num = 3'd2;
    for (int b = 0; b < 4; b++)
      for (int n = 0; n < 2; n++) begin
        wbuf[0] = 16'($urandom); wbuf[1] = 16'($urandom);
        wr_burst(b, n, 2);
      end
    do_swap(1'b1);
    stream_nodes = 5'd2;
    tag = int'($urandom_range(0, 3));
    stream_begin = 1'b1;
    req_valid[2] = 1'b1; req_rd_wr[2] = 1'b1; req_node_id[8 +: 4] = 4'd0; req_pe_tag[4 +: 2] = tag[1:0];
    #1;
    chk("sb_ready_block", req_ready, 4'h0);
    tick;
    stream_begin = 1'b0;
    #1;
    chk("sb_avail_busy", available, 1'b0);
    chk("sb_no_beat_yet", sm_valid, 4'h0);
    tick;
    for (int j = 0; j < 4; j++) begin
      #1;
      for (int b = 0; b < 4; b++) begin
        chk("sm_valid", sm_valid[b], 1'b1);
        chk("sm_addr", sm_addr[b*4 +: 4], 4'(j / 2));
        chk("sm_sos", sm_sos[b], (j % 2) == 0);
        chk("sm_eos", sm_eos[b], (j % 2) == 1);
        chk("sm_data", sm_data[b*16 +: 16], mdl[b][hsel][j/2][j%2]);
      end
      if (j == 3) begin
        chk("sm_avail_end", available, 1'b1);
        chk("sm_held_req_ready", req_ready[2], 1'b1);
      end
      tick;
    end
    #1;
    chk("sm_done", sm_valid, 4'h0);
    rd_collect(2, 0, tag, 2, 1'b0);

    // Swap while idle exposes new data; swap during a read is ignored.
    fv = 4; fv_num = 3'd4;
    for (int i = 0; i < 4; i++) wbuf[i] = 16'($urandom);
    wr_burst(0, 5, 4);
    do_swap(1'b1);
    rd_issue(0, 5, 1);
    rd_collect(0, 5, 1, 4, 1'b1);

    // fv_num=0 acts as a single-beat vector.
    fv = 1; fv_num = 3'd0;
    wbuf[0] = 16'($urandom);
    wr_burst(1, 2, 1);
    do_swap(1'b1);
    rd_issue(1, 2, 3);
    rd_collect(1, 2, 3, 1, 1'b0);

    // Overlong vector on bank3 and headless write on bank2.
    fv = 4; fv_num = 3'd4;
    for (int i = 0; i < 5; i++) wbuf[i] = 16'($urandom);
    wr_burst(3, 7, 5);
    do_swap(1'b1);
    rd_issue(3, 7, 0);
    rd_collect(3, 7, 0, 4, 1'b0);
    req_valid[2] = 1'b1; req_rd_wr[2] = 1'b0; req_sos[2] = 1'b0; req_eos[2] = 1'b0;
    req_node_id[8 +: 4] = 4'd9; req_data[32 +: 16] = 16'($urandom);
    tick;
    req_valid[2] = 1'b0;
    #1;
    chk("headless_avail", available, 1'b1);
    chk("headless_ready", req_ready[2], 1'b1);
`ifdef BIG_FV_PROTOCOL_CHK_EN
    exp_perr = 4'b1100;
`else
    exp_perr = 4'b0000;
`endif
    chk("proto_err", proto_err, exp_perr);

    // Reset during the third stream beat.
    fv = 2; fv_num = 3'd2; stream_nodes = 5'd2;
    stream_begin = 1'b1;
    tick;
    stream_begin = 1'b0;
    repeat (3) tick;
    #1;
    chk("mid_sm_valid", sm_valid, 4'hF);
    chk("mid_sm_addr", sm_addr, 16'h1111);
    chk("mid_half_sel", half_sel, hsel[0]);
    reset = 1'b1;
    tick;
    hsel = 0;
    #1;
    chk("rst2_sm_valid", sm_valid, 4'h0);
    chk("rst2_sm_sos_eos", {sm_sos, sm_eos}, 8'h00);
    chk("rst2_sm_addr", sm_addr, 16'h0);
    chk("rst2_sm_data", sm_data, 64'h0);
    chk("rst2_rd_valid", rd_valid, 4'h0);
    chk("rst2_available", available, 1'b1);
    chk("rst2_half_sel", half_sel, 1'b0);
    chk("rst2_proto_err", proto_err, 4'h0);
    reset = 1'b0;
    tick;
    #1;
    chk("post_rst_avail", available, 1'b1);
    chk("post_rst_sm", sm_valid, 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
